// File: rtl/synth_voice_alloc.sv
// Polyphonic voice allocator for the synth keyboard: decodes PS/2 make/break
// sequences for 36 keys, assigns held keys to voices, steals round-robin when full.
module synth_voice_alloc #(
  parameter int NUM_VOICES = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [7:0]              scan_data,
  input  logic                    scan_valid,
  input  logic                    all_off,
  output logic [15:0]             key_press,
  output logic [6*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [NUM_VOICES-1:0]   voice_on,
  output logic                    steal
);

  localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXTBRK
  } state_t;

  // Returns {mapped, note}; note = 12*octave + semitone.
  function automatic logic [6:0] note_lookup(input logic [7:0] code);
    logic [6:0] res;
    res = 7'd0;
    case (code)
      8'h16: res = {1'b1, 6'd0};
      8'h1E: res = {1'b1, 6'd1};
      8'h26: res = {1'b1, 6'd2};
      8'h25: res = {1'b1, 6'd3};
      8'h2E: res = {1'b1, 6'd4};
      8'h36: res = {1'b1, 6'd5};
      8'h3D: res = {1'b1, 6'd6};
      8'h3E: res = {1'b1, 6'd7};
      8'h46: res = {1'b1, 6'd8};
      8'h45: res = {1'b1, 6'd9};
      8'h4E: res = {1'b1, 6'd10};
      8'h55: res = {1'b1, 6'd11};
      8'h15: res = {1'b1, 6'd12};
      8'h1D: res = {1'b1, 6'd13};
      8'h24: res = {1'b1, 6'd14};
      8'h2D: res = {1'b1, 6'd15};
      8'h2C: res = {1'b1, 6'd16};
      8'h35: res = {1'b1, 6'd17};
      8'h3C: res = {1'b1, 6'd18};
      8'h43: res = {1'b1, 6'd19};
      8'h44: res = {1'b1, 6'd20};
      8'h4D: res = {1'b1, 6'd21};
      8'h54: res = {1'b1, 6'd22};
      8'h5B: res = {1'b1, 6'd23};
      8'h1C: res = {1'b1, 6'd24};
      8'h1B: res = {1'b1, 6'd25};
      8'h23: res = {1'b1, 6'd26};
      8'h2B: res = {1'b1, 6'd27};
      8'h34: res = {1'b1, 6'd28};
      8'h33: res = {1'b1, 6'd29};
      8'h3B: res = {1'b1, 6'd30};
      8'h42: res = {1'b1, 6'd31};
      8'h4B: res = {1'b1, 6'd32};
      8'h4C: res = {1'b1, 6'd33};
      8'h52: res = {1'b1, 6'd34};
      8'h4A: res = {1'b1, 6'd35};
      default: res = 7'd0;
    endcase
    return res;
  endfunction

  state_t                  r_state;
  logic [15:0]             r_key_press;
  logic [6*NUM_VOICES-1:0] r_note;
  logic [NUM_VOICES-1:0]   r_active;
  logic [NUM_VOICES-1:0]   r_on;
  logic                    r_steal;
  logic [PTR_W-1:0]        r_steal_ptr;

  state_t                  w_state_nxt;
  logic                    w_make;
  logic                    w_brk;
  logic [6:0]              w_lookup;
  logic                    w_mapped;
  logic [5:0]              w_note;
  logic                    w_hit;
  logic [PTR_W-1:0]        w_hit_idx;
  logic                    w_free;
  logic [PTR_W-1:0]        w_free_idx;
  logic                    w_alloc;
  logic                    w_clear;
  logic [PTR_W-1:0]        w_sel;
  logic [6*NUM_VOICES-1:0] w_note_nxt;
  logic [NUM_VOICES-1:0]   w_active_nxt;
  logic [NUM_VOICES-1:0]   w_on_nxt;
  logic                    w_steal_nxt;
  logic [PTR_W-1:0]        w_ptr_nxt;

  assign w_lookup = note_lookup(scan_data);
  assign w_mapped = w_lookup[6];
  assign w_note   = w_lookup[5:0];

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    if (scan_valid) begin
      case (r_state)
        S_IDLE: begin
          if (scan_data == 8'hF0)      w_state_nxt = S_BRK;
          else if (scan_data == 8'hE0) w_state_nxt = S_EXT;
          else                         w_make      = 1'b1;
        end
        S_BRK: begin
          w_brk       = 1'b1;
          w_state_nxt = S_IDLE;
        end
        S_EXT:    w_state_nxt = (scan_data == 8'hF0) ? S_EXTBRK : S_IDLE;
        S_EXTBRK: w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Downward scan so the lowest-index match/free voice is the one left standing.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (r_active[v] && (r_note[6*v +: 6] == w_note)) begin
        w_hit     = 1'b1;
        w_hit_idx = PTR_W'(v);
      end
      if (!r_active[v]) begin
        w_free     = 1'b1;
        w_free_idx = PTR_W'(v);
      end
    end
  end

  always_comb begin
    w_active_nxt = r_active;
    w_note_nxt   = r_note;
    w_on_nxt     = '0;
    w_steal_nxt  = 1'b0;
    w_ptr_nxt    = r_steal_ptr;
    w_sel        = w_free_idx;
    w_alloc      = 1'b0;
    w_clear      = 1'b0;
    if (all_off) begin
      w_active_nxt = '0;
      w_ptr_nxt    = '0;
    end else if (w_make && w_mapped && !w_hit) begin
      w_alloc = 1'b1;
      if (!w_free) begin
        w_sel       = r_steal_ptr;
        w_steal_nxt = 1'b1;
        w_ptr_nxt   = (r_steal_ptr == PTR_W'(NUM_VOICES - 1)) ? '0 : r_steal_ptr + PTR_W'(1);
      end
    end else if (w_brk && w_mapped && w_hit) begin
      w_clear = 1'b1;
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (w_alloc && (w_sel == PTR_W'(v))) begin
        w_note_nxt[6*v +: 6] = w_note;
        w_active_nxt[v]      = 1'b1;
        w_on_nxt[v]          = 1'b1;
      end
      if (w_clear && (w_hit_idx == PTR_W'(v))) begin
        w_active_nxt[v] = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_key_press <= '0;
      r_note      <= '0;
      r_active    <= '0;
      r_on        <= '0;
      r_steal     <= 1'b0;
      r_steal_ptr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      if (scan_valid) begin
        r_key_press <= {r_key_press[7:0], scan_data};
      end
      r_note      <= w_note_nxt;
      r_active    <= w_active_nxt;
      r_on        <= w_on_nxt;
      r_steal     <= w_steal_nxt;
      r_steal_ptr <= w_ptr_nxt;
    end
  end

  assign key_press    = r_key_press;
  assign voice_note   = r_note;
  assign voice_active = r_active;
  assign voice_on     = r_on;
  assign steal        = r_steal;

endmodule

// File: tb/tb_synth_voice_alloc.sv
// Directed bench for synth_voice_alloc: a key-level behavioural model is compared
// against the DUT every cycle, plus hand-computed expectations after key bytes.
module tb_synth_voice_alloc;

  localparam int NV = 4;

  logic              clk;
  logic              resetn;
  logic [7:0]        scan_data;
  logic              scan_valid;
  logic              all_off;
  logic [15:0]       key_press;
  logic [6*NV-1:0]   voice_note;
  logic [NV-1:0]     voice_active;
  logic [NV-1:0]     voice_on;
  logic              steal;

  synth_voice_alloc #(.NUM_VOICES(NV)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .scan_data    (scan_data),
    .scan_valid   (scan_valid),
    .all_off      (all_off),
    .key_press    (key_press),
    .voice_note   (voice_note),
    .voice_active (voice_active),
    .voice_on     (voice_on),
    .steal        (steal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Keys listed by note index.
  logic [7:0] keymap [36] = '{
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B,
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C, 8'h52, 8'h4A
  };

  function automatic int lookup(input logic [7:0] c);
    for (int i = 0; i < 36; i++) if (keymap[i] == c) return i;
    return -1;
  endfunction

  // Model: which key each voice holds, whether it sounds, and the sequence prefix seen so far.
  logic [5:0]  m_note [NV];
  bit [NV-1:0] m_act;
  bit [NV-1:0] m_on;
  bit          m_steal;
  int          m_ptr;
  logic [15:0] m_kp;
  bit          m_after_f0;
  bit          m_in_ext;
  bit          ev_make, ev_brk;
  int          n, hit, fr;

  always @(posedge clk) begin
    if (!resetn) begin
      for (int v = 0; v < NV; v++) m_note[v] = 6'd0;
      m_act = '0; m_on = '0; m_steal = 1'b0; m_ptr = 0; m_kp = 16'h0;
      m_after_f0 = 1'b0; m_in_ext = 1'b0;
    end else begin
      m_on = '0; m_steal = 1'b0; ev_make = 1'b0; ev_brk = 1'b0;
      if (scan_valid) begin
        m_kp = {m_kp[7:0], scan_data};
        if (m_in_ext) begin
          if (scan_data == 8'hF0 && !m_after_f0) m_after_f0 = 1'b1;
          else begin m_in_ext = 1'b0; m_after_f0 = 1'b0; end
        end else if (m_after_f0) begin
          ev_brk = 1'b1; m_after_f0 = 1'b0;
        end else if (scan_data == 8'hE0) m_in_ext = 1'b1;
        else if (scan_data == 8'hF0) m_after_f0 = 1'b1;
        else ev_make = 1'b1;
      end
      n = lookup(scan_data);
      hit = -1; fr = -1;
      for (int v = NV - 1; v >= 0; v--) begin
        if (n >= 0 && m_act[v] && m_note[v] == n[5:0]) hit = v;
        if (!m_act[v]) fr = v;
      end
      if (all_off) begin
        m_act = '0; m_ptr = 0;
      end else if (ev_make && n >= 0 && hit < 0) begin
        if (fr < 0) begin
          fr = m_ptr; m_steal = 1'b1; m_ptr = (m_ptr + 1) % NV;
        end
        m_note[fr] = n[5:0]; m_act[fr] = 1'b1; m_on[fr] = 1'b1;
      end else if (ev_brk && hit >= 0) begin
        m_act[hit] = 1'b0;
      end
    end
  end

  logic [6*NV-1:0] exp_note;
  always_comb begin
    exp_note = '0;
    for (int v = 0; v < NV; v++) exp_note[6*v +: 6] = m_note[v];
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("key_press", 32'(key_press), 32'(m_kp));
      check("voice_note", 32'(voice_note), 32'(exp_note));
      check("voice_active", 32'(voice_active), 32'(m_act));
      check("voice_on", 32'(voice_on), 32'(m_on));
      check("steal", 32'(steal), 32'(m_steal));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte was sampled.
  task automatic send(input logic [7:0] b, input logic off = 1'b0);
    scan_data  = b;
    scan_valid = 1'b1;
    all_off    = off;
    @(posedge clk); #1;
    scan_valid = 1'b0;
    all_off    = 1'b0;
  endtask

  task automatic panic();
    all_off = 1'b1;
    @(posedge clk); #1;
    all_off = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; scan_data = 8'h00; scan_valid = 1'b0; all_off = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    chk_en = 1'b1;
    check("reset key_press", 32'(key_press), 32'h0);
    check("reset active", 32'(voice_active), 32'h0);
    check("reset note", 32'(voice_note), 32'h0);

    // Make then break of 1C
    send(8'h1C);
    check("1C active", 32'(voice_active), 32'b0001);
    check("1C note0", 32'(voice_note[5:0]), 32'd24);
    check("1C on", 32'(voice_on), 32'b0001);
    check("1C key_press", 32'(key_press), 32'h001C);
    send(8'hF0);
    send(8'h1C);
    check("brk 1C active", 32'(voice_active), 32'b0000);
    check("brk 1C key_press", 32'(key_press), 32'hF01C);

    // Fill all voices, then steal twice
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    check("fill active", 32'(voice_active), 32'b1111);
    check("fill notes", 32'(voice_note), 32'({6'd3, 6'd2, 6'd1, 6'd0}));
    send(8'h2E);
    check("steal0 pulse", 32'(steal), 32'd1);
    check("steal0 on", 32'(voice_on), 32'b0001);
    check("steal0 note", 32'(voice_note[5:0]), 32'd4);
    send(8'h36);
    check("steal1 on", 32'(voice_on), 32'b0010);
    check("steal1 note", 32'(voice_note[11:6]), 32'd5);
    panic();
    check("panic active", 32'(voice_active), 32'd0);

    // Typematic repeat, break, redundant break
    send(8'h16);
    check("typ first on", 32'(voice_on), 32'b0001);
    send(8'h16);
    check("typ repeat on", 32'(voice_on), 32'd0);
    send(8'h16);
    send(8'hF0); send(8'h16);
    check("typ brk active", 32'(voice_active), 32'd0);
    send(8'hF0); send(8'h16);
    check("typ brk2 active", 32'(voice_active), 32'd0);

    // Extended and unmapped codes
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h5A);
    check("ext active", 32'(voice_active), 32'd0);
    check("ext key_press", 32'(key_press), 32'h755A);
    send(8'hE0); send(8'h16);
    check("ext mapped ignored", 32'(voice_active), 32'd0);

    // all_off together with a make byte
    send(8'h16); send(8'h1E);
    check("pre-off active", 32'(voice_active), 32'b0011);
    send(8'h3E, 1'b1);
    check("off+make active", 32'(voice_active), 32'd0);
    check("off+make on", 32'(voice_on), 32'd0);
    check("off+make kp low", 32'(key_press[7:0]), 32'h3E);
    send(8'h3E);
    check("post-off make on", 32'(voice_on), 32'b0001);

    // Steal pointer wraps 3 -> 0
    panic();
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    send(8'h2E); send(8'h36); send(8'h3D); send(8'h3E);
    check("wrap v3 on", 32'(voice_on), 32'b1000);
    send(8'h46);
    check("wrap v0 on", 32'(voice_on), 32'b0001);
    check("wrap v0 note", 32'(voice_note[5:0]), 32'd8);
    check("wrap steal", 32'(steal), 32'd1);
    panic();

    // Reset right after F0 discards the break prefix
    send(8'hF0);
    do_reset();
    send(8'h16);
    check("rst-mid active", 32'(voice_active), 32'b0001);
    check("rst-mid on", 32'(voice_on), 32'b0001);
    check("rst-mid note", 32'(voice_note[5:0]), 32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
